matvec_loader: RTL and testbench
================================

// Module: matvec_loader
// PURPOSE
//   Feeder side of the matvec_mult engine. Takes one frame of 72 bytes on a valid/ready byte stream:
//   B vector (8 B) first, then A (64 B, row-major). Writes B into the B FIFO and row i of A into A FIFO i,
//   then pulses start to matvec_mult and holds busy until its done returns. Sits between host/memory and the MAC array.
// PARAMETERS
//   DIM     8  matrix/vector dimension (rows of A = length of B)
//   DATA_W  8  element width, bits
// PORTS
//   clk         in   1            system clock; all logic on posedge
//   rst         in   1            synchronous, active-high reset
//   go          in   1            one-cycle request to begin a frame (honoured only in IDLE)
//   in_valid    in   1            stream byte valid
//   in_ready    out  1            loader accepts in_data this cycle
//   in_data     in   DATA_W       stream element
//   b_full      in   1            B FIFO full
//   a_full      in   DIM          A FIFO i full
//   b_wr_en     out  1            write strobe, B FIFO
//   a_wr_en     out  DIM          write strobe, A FIFO i (one-hot or zero)
//   wr_data     out  DATA_W       data to the FIFOs (= in_data)
//   mv_clr      out  1            one-cycle Clr pulse to matvec_mult
//   mv_start    out  1            one-cycle start pulse to matvec_mult
//   mv_done     in   1            done from matvec_mult
//   busy        out  1            high in every state except IDLE
// BEHAVIOUR
//   - Reset: state=IDLE, counters=0; in_ready, b_wr_en, a_wr_en, mv_clr, mv_start, busy all 0. Reset mid-frame
//     abandons the frame; no recovery of partial FIFO contents (upstream must also Clr).
//   - FSM: IDLE -go-> LOAD_B (mv_clr=1 on the cycle after go, i.e. first LOAD_B cycle).
//     LOAD_B: 8 transfers -> LOAD_A. LOAD_A: 64 transfers -> FIRE. FIRE: mv_start=1 for exactly 1 cycle -> WAIT_DONE.
//     WAIT_DONE: mv_done=1 -> IDLE (busy drops the following cycle).
//   - Handshake: transfer = in_valid & in_ready. in_ready = (LOAD_B & !b_full) | (LOAD_A & !a_full[row]).
//     in_ready is not dependent on in_valid. Strobes are combinational in the transfer cycle; wr_data = in_data.
//   - Indexing: b_idx counts 0..DIM-1. a_cnt counts 0..DIM*DIM-1; row = a_cnt/DIM, col = a_cnt%DIM.
//     a_wr_en = 1<<row on transfer. Counters clear on entry to LOAD_B. Last B byte and first A byte are in
//     consecutive cycles (no bubble).
//   - Full: the targeted FIFO full -> in_ready=0, no strobe, counter holds; resumes when full drops.
//   - Ignored events: go outside IDLE; mv_done outside WAIT_DONE; in_valid outside LOAD_B/LOAD_A (in_ready=0).
//     go and rst together: rst wins.
//   - Widths: counters are $clog2(DIM*DIM)+1 bits. No arithmetic on the data path.
// CONFIGURATION
//   MATVEC_LOADER_PERF_EN defined: adds output stall_cnt [15:0]. Increments on every cycle in LOAD_B/LOAD_A
//     with in_valid=1 & in_ready=0. Saturates at 16'hFFFF. Clears on rst and on go accepted.
//   Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//   - matvec_pkg: DIM and DATA_W defaults, typedef enum logic [2:0] ldr_state_t
//     {IDLE, LOAD_B, LOAD_A, FIRE, WAIT_DONE}.
//   - Single module; FSM, counters and strobe decode inline. No sub-module.
// TESTING
//   1. Reset: rst=1 for 2 cycles with go=1, in_valid=1 -> all outputs 0, busy=0; release -> still IDLE.
//   2. Full frame, in_valid held 1, no full: B=1..8, A[i][j]=8*i+j -> b_wr_en high for 8 cycles with
//      wr_data 1..8. A FIFO 3 gets 24..31. mv_start pulses exactly 1 cycle, 73 cycles after the first
//      LOAD_B cycle. busy falls 1 cycle after mv_done.
//   3. Backpressure: a_full[2]=1 for 5 cycles during row 2 -> in_ready=0 and no strobes for those 5 cycles.
//      No byte lost or duplicated; PERF_EN build: stall_cnt=5.
//   4. Gappy source: in_valid toggling 1/0 -> same FIFO contents as test 2. Frame completes after 72 transfers.
//   5. Spurious: go during LOAD_A and mv_done during LOAD_B -> no state change, no mv_clr/mv_start.
//   6. Reset mid-frame: rst after 20 transfers -> IDLE next cycle. A new go + 72 bytes -> mv_clr then
//      normal completion.

Source files
------------

// File: rtl/matvec_loader_pkg.sv
// Shared sizes and FSM encoding for the matvec feeder (matvec_loader).
// Imported by the loader and its bench.
package matvec_pkg;

    localparam int DIM       = 8;
    localparam int DATA_W    = 8;
    localparam int FRAME_LEN = DIM + DIM * DIM;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_B,
        LOAD_A,
        FIRE,
        WAIT_DONE
    } ldr_state_t;

endpackage

// File: rtl/matvec_loader.sv
// Byte-stream feeder for matvec_mult: B vector then row-major A into the FIFOs.
// Optional MATVEC_LOADER_PERF_EN adds a saturating stall counter output.
module matvec_loader #(
    parameter int DIM    = matvec_pkg::DIM,
    parameter int DATA_W = matvec_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              b_full,
    input  logic [DIM-1:0]    a_full,
    output logic              b_wr_en,
    output logic [DIM-1:0]    a_wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              mv_clr,
    output logic              mv_start,
    input  logic              mv_done,
    output logic              busy
`ifdef MATVEC_LOADER_PERF_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    import matvec_pkg::*;

    localparam int CNT_W = $clog2(DIM * DIM) + 1;
    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1;

    localparam logic [CNT_W-1:0] B_LAST = CNT_W'(DIM - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(DIM * DIM - 1);
    localparam logic [CNT_W-1:0] DIM_C  = CNT_W'(DIM);

    ldr_state_t       state;
    logic [CNT_W-1:0] b_idx;
    logic [CNT_W-1:0] a_cnt;
    logic [ROW_W-1:0] row;
    logic             load_b;
    logic             load_a;
    logic             xfer;

    assign load_b = (state == LOAD_B);
    assign load_a = (state == LOAD_A);

    // Row of A currently being streamed; selects both the full flag and the strobe.
    assign row = ROW_W'(a_cnt / DIM_C);

    assign in_ready = (load_b & ~b_full)
                    | (load_a & ~a_full[row]);

    assign xfer    = in_valid & in_ready;
    assign b_wr_en = xfer & load_b;
    assign a_wr_en = (xfer & load_a) ? (DIM'(1) << row) : '0;
    assign wr_data = in_data;
    assign busy    = (state != IDLE);

    // Frame sequencer: counters, state and the registered clr/start pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            b_idx    <= '0;
            a_cnt    <= '0;
            mv_clr   <= 1'b0;
            mv_start <= 1'b0;
        end else begin
            mv_clr   <= 1'b0;
            mv_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state  <= LOAD_B;
                        b_idx  <= '0;
                        a_cnt  <= '0;
                        mv_clr <= 1'b1;
                    end
                end
                LOAD_B: begin
                    if (xfer) begin
                        if (b_idx == B_LAST) begin
                            state <= LOAD_A;
                            b_idx <= '0;
                        end else begin
                            b_idx <= b_idx + 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    if (xfer) begin
                        if (a_cnt == A_LAST) begin
                            state <= FIRE;
                            a_cnt <= '0;
                        end else begin
                            a_cnt <= a_cnt + 1'b1;
                        end
                    end
                end
                FIRE: begin
                    mv_start <= 1'b1;
                    state    <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (mv_done) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef MATVEC_LOADER_PERF_EN
    // Count cycles where the source offered a byte but the target FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((state == IDLE) && go) begin
            stall_cnt <= '0;
        end else if ((load_b | load_a) && in_valid && !in_ready
                     && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_matvec_loader.sv
// Self-checking bench for matvec_loader: scenario table, random frames,
// reset and mid-frame reset sequences, FIFO contents scoreboard.
module tb_matvec_loader;

    import matvec_pkg::*;

    typedef struct {
        int valid_mode;    // 0 held, 1 toggle, 2 random
        int bp_row;        // -1 none, DIM = B FIFO, else A row
        int bp_at;         // byte index at which backpressure starts
        int bp_len;        // cycles of backpressure
        int rand_full;     // random full flags every cycle
        int spur_go_k;     // byte index where go is pulsed (-1 none)
        int spur_done_k;   // byte index where mv_done is pulsed (-1 none)
        int exp_stall;     // expected stall count (-1 = from model)
        int exp_lat;       // expected mv_start cycle (-1 = from model)
    } scen_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              b_full;
    logic [DIM-1:0]    a_full;
    logic              b_wr_en;
    logic [DIM-1:0]    a_wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              mv_clr;
    logic              mv_start;
    logic              mv_done;
    logic              busy;
`ifdef MATVEC_LOADER_PERF_EN
    logic [15:0]       stall_cnt;
`endif

    always #5 clk = ~clk;

    matvec_loader dut (
        .clk      (clk),
        .rst      (rst),
        .go       (go),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .b_full   (b_full),
        .a_full   (a_full),
        .b_wr_en  (b_wr_en),
        .a_wr_en  (a_wr_en),
        .wr_data  (wr_data),
        .mv_clr   (mv_clr),
        .mv_start (mv_start),
        .mv_done  (mv_done),
        .busy     (busy)
`ifdef MATVEC_LOADER_PERF_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] got_b[$];
    logic [DATA_W-1:0] got_a[DIM][$];

    // FIFO models: whatever the strobes write lands here.
    always @(negedge clk) begin
        if (b_wr_en === 1'b1) got_b.push_back(wr_data);
        for (int i = 0; i < DIM; i++)
            if (a_wr_en[i] === 1'b1) got_a[i].push_back(wr_data);
    end

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic clear_fifos();
        got_b.delete();
        for (int i = 0; i < DIM; i++) got_a[i].delete();
    endtask

    task automatic idle_inputs();
        go = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        b_full = 1'b0;
        a_full = '0;
        mv_done = 1'b0;
    endtask

    task automatic run_frame(input scen_t s, input int id);
        logic [DATA_W-1:0] data[FRAME_LEN];
        logic [DIM-1:0]    exp_a;
        logic              exp_ready;
        logic              tfull;
        logic              xfer;
        int k = 0, cyc = 0, stall = 0, bp_left = 0;
        int t_last = -1, n_start = 0, start_cyc = -1;
        bit bp_started = 0;
        string tag;
        tag = $sformatf("s%0d", id);
        for (int i = 0; i < FRAME_LEN; i++)
            data[i] = (s.valid_mode == 2) ? DATA_W'($urandom)
                    : (i < DIM) ? DATA_W'(i + 1) : DATA_W'(i - DIM);
        clear_fifos();
        idle_inputs();
        go = 1'b1;
        @(negedge clk);
        check({tag, " busy_pre_go"}, busy, 0);
        @(posedge clk); #1;
        go = 1'b0;
        while (k < FRAME_LEN && cyc < 3000) begin
            case (s.valid_mode)
                0: in_valid = 1'b1;
                1: in_valid = (cyc % 2 == 0);
                default: in_valid = ($urandom_range(0, 9) < 7);
            endcase
            in_data = in_valid ? data[k] : DATA_W'($urandom);
            b_full = 1'b0;
            a_full = '0;
            if (s.rand_full != 0) begin
                b_full = ($urandom_range(0, 3) == 0);
                a_full = DIM'($urandom & $urandom);
            end
            if (s.bp_row >= 0 && !bp_started && k == s.bp_at) begin
                bp_started = 1;
                bp_left = s.bp_len;
            end
            if (bp_left > 0) begin
                if (s.bp_row == DIM) b_full = 1'b1;
                else a_full[s.bp_row] = 1'b1;
                bp_left--;
            end
            go = (k == s.spur_go_k);
            mv_done = (k == s.spur_done_k);
            tfull = (k < DIM) ? b_full : a_full[(k - DIM) / DIM];
            exp_ready = !tfull;
            xfer = in_valid && exp_ready;
            exp_a = '0;
            if (xfer && k >= DIM) exp_a[(k - DIM) / DIM] = 1'b1;
            @(negedge clk);
            check({tag, " in_ready"}, in_ready, exp_ready);
            check({tag, " b_wr_en"}, b_wr_en, xfer && (k < DIM));
            check({tag, " a_wr_en"}, a_wr_en, exp_a);
            if (xfer) check({tag, " wr_data"}, wr_data, data[k]);
            check({tag, " mv_clr"}, mv_clr, (cyc == 0));
            check({tag, " mv_start_early"}, mv_start, 0);
            check({tag, " busy_load"}, busy, 1);
            if (in_valid && !exp_ready) stall++;
            if (xfer) begin
                k++;
                t_last = cyc;
            end
            cyc++;
            @(posedge clk); #1;
        end
        if (k < FRAME_LEN) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes expected %0d",
                     tag, k, FRAME_LEN);
        end
        idle_inputs();
        in_valid = 1'b1;
        for (int w = 0; w < 4; w++) begin
            @(negedge clk);
            if (mv_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
            end
            check({tag, " in_ready_post"}, in_ready, 0);
            check({tag, " busy_post"}, busy, 1);
            cyc++;
            @(posedge clk); #1;
        end
        check({tag, " start_pulses"}, n_start, 1);
        check({tag, " start_cycle"}, start_cyc,
              (s.exp_lat >= 0) ? s.exp_lat : t_last + 2);
`ifdef MATVEC_LOADER_PERF_EN
        check({tag, " stall_cnt"}, stall_cnt,
              (s.exp_stall >= 0) ? s.exp_stall : stall);
`endif
        in_valid = 1'b0;
        mv_done = 1'b1;
        @(negedge clk);
        check({tag, " busy_at_done"}, busy, 1);
        @(posedge clk); #1;
        mv_done = 1'b0;
        @(negedge clk);
        check({tag, " busy_after_done"}, busy, 0);
        check({tag, " b_count"}, got_b.size(), DIM);
        for (int j = 0; j < DIM && j < got_b.size(); j++)
            check({tag, " b_data"}, got_b[j], data[j]);
        for (int i = 0; i < DIM; i++) begin
            check({tag, " a_count"}, got_a[i].size(), DIM);
            for (int j = 0; j < DIM && j < got_a[i].size(); j++)
                check({tag, " a_data"}, got_a[i][j], data[DIM + i * DIM + j]);
        end
        @(posedge clk); #1;
    endtask

    scen_t tbl[8];

    initial begin
        tbl[0] = '{0, -1,  0, 0, 0, -1, -1,  0,  73};
        tbl[1] = '{0,  2, 27, 5, 0, -1, -1,  5,  78};
        tbl[2] = '{1, -1,  0, 0, 0, -1, -1,  0, 144};
        tbl[3] = '{0, -1,  0, 0, 0, 30,  3,  0,  73};
        tbl[4] = '{0, DIM, 2, 3, 0, -1, -1,  3,  76};
        tbl[5] = '{2, -1,  0, 0, 1, -1, -1, -1,  -1};
        tbl[6] = '{2, -1,  0, 0, 1, 40,  5, -1,  -1};
        tbl[7] = '{2,  5, 50, 4, 1, -1, -1, -1,  -1};

        idle_inputs();
        rst = 1'b1;
        go = 1'b1;
        in_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("rst in_ready", in_ready, 0);
            check("rst b_wr_en", b_wr_en, 0);
            check("rst a_wr_en", a_wr_en, 0);
            check("rst mv_clr", mv_clr, 0);
            check("rst mv_start", mv_start, 0);
            check("rst busy", busy, 0);
`ifdef MATVEC_LOADER_PERF_EN
            check("rst stall_cnt", stall_cnt, 0);
`endif
        end
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        in_valid = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("post_rst busy", busy, 0);
        check("post_rst in_ready", in_ready, 0);
        check("post_rst mv_clr", mv_clr, 0);
        @(posedge clk); #1;

        for (int t = 0; t < 8; t++) run_frame(tbl[t], t);

        idle_inputs();
        go = 1'b1;
        @(posedge clk); #1;
        go = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_data = DATA_W'(c);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst in_ready", in_ready, 0);
        check("midrst a_wr_en", a_wr_en, 0);
        check("midrst mv_start", mv_start, 0);
`ifdef MATVEC_LOADER_PERF_EN
        check("midrst stall_cnt", stall_cnt, 0);
`endif
        @(posedge clk); #1;
        run_frame(tbl[0], 8);

        for (int r = 0; r < 4; r++) run_frame(tbl[5], 9 + r);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
